// File: rtl/hazard_unit.sv
// Hazard unit for the 5-stage MIPS pipeline: load-use, branch-operand and mul/div
// stall detection, E/D forwarding selects, taken-branch flush and a stall counter.

module hazardLane #(
   parameter int ADDR_W = 5
) (
   input  logic [ADDR_W-1:0] srcE,
   input  logic [ADDR_W-1:0] srcD,
   input  logic              useD,
   input  logic              branchD,
   input  logic [ADDR_W-1:0] dstE,
   input  logic [ADDR_W-1:0] dstM,
   input  logic              regwriteM,
   input  logic              memreadM,
   input  logic [ADDR_W-1:0] dstW,
   input  logic              regwriteW,
   output logic [1:0]        fwdE,
   output logic              fwdD,
   output logic              hitE,
   output logic              hitM
);
   logic fwdM, fwdW;

   // Register 0 is hardwired, so a zero destination never matches anything.
   assign fwdM = regwriteM && (dstM != '0) && (dstM == srcE);
   assign fwdW = regwriteW && (dstW != '0) && (dstW == srcE);
   assign fwdE = fwdM ? 2'b10 : (fwdW ? 2'b01 : 2'b00);

   assign fwdD = branchD && regwriteM && !memreadM && (dstM != '0) && (dstM == srcD);

   assign hitE = useD && (dstE != '0) && (dstE == srcD);
   assign hitM = useD && (dstM != '0) && (dstM == srcD);
endmodule

module hazard_unit #(
   parameter int ADDR_W   = 5,
   parameter int LOAD_LAT = 1,
   parameter int MD_LAT   = 4,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] rs_d,
   input  logic [ADDR_W-1:0] rt_d,
   input  logic              use_rs_d,
   input  logic              use_rt_d,
   input  logic              branch_d,
   input  logic              taken_d,
   input  logic              md_use_d,
   input  logic [ADDR_W-1:0] rs_e,
   input  logic [ADDR_W-1:0] rt_e,
   input  logic [ADDR_W-1:0] dst_e,
   input  logic              regwrite_e,
   input  logic              memread_e,
   input  logic              md_start_e,
   input  logic [ADDR_W-1:0] dst_m,
   input  logic              regwrite_m,
   input  logic              memread_m,
   input  logic [ADDR_W-1:0] dst_w,
   input  logic              regwrite_w,
   input  logic              cnt_clr,
   output logic              stall_f,
   output logic              stall_d,
   output logic              flush_d,
   output logic              flush_e,
   output logic [1:0]        fwd_a_e,
   output logic [1:0]        fwd_b_e,
   output logic              fwd_a_d,
   output logic              fwd_b_d,
   output logic              md_busy,
   output logic [CNT_W-1:0]  stall_cnt
);
   localparam int NUM_SRC = 2;
   localparam int LD_W    = (LOAD_LAT > 1) ? $clog2(LOAD_LAT) : 1;
   localparam int MD_W    = $clog2(MD_LAT + 1);
   localparam logic [LD_W-1:0] LD_INIT = LD_W'(LOAD_LAT - 1);
   localparam logic [MD_W-1:0] MD_INIT = MD_W'(MD_LAT);

   logic [NUM_SRC-1:0][ADDR_W-1:0] srcE, srcD;
   logic [NUM_SRC-1:0][1:0]        fwdE;
   logic [NUM_SRC-1:0]             useD, fwdD, hitE, hitM;
   logic [LD_W-1:0]                ldCnt;
   logic [MD_W-1:0]                mdCnt;
   logic                           lu, brE, brM, md, hz;

   // Lane 0 is the rs/A operand, lane 1 the rt/B operand.
   assign srcE = {rt_e, rs_e};
   assign srcD = {rt_d, rs_d};
   assign useD = {use_rt_d, use_rs_d};

   generate
      for (genvar i = 0; i < NUM_SRC; i++) begin : gLane
         hazardLane #(.ADDR_W(ADDR_W)) uLane (
            .srcE      (srcE[i]),
            .srcD      (srcD[i]),
            .useD      (useD[i]),
            .branchD   (branch_d),
            .dstE      (dst_e),
            .dstM      (dst_m),
            .regwriteM (regwrite_m),
            .memreadM  (memread_m),
            .dstW      (dst_w),
            .regwriteW (regwrite_w),
            .fwdE      (fwdE[i]),
            .fwdD      (fwdD[i]),
            .hitE      (hitE[i]),
            .hitM      (hitM[i])
         );
      end
   endgenerate

   assign fwd_a_e = fwdE[0];
   assign fwd_b_e = fwdE[1];
   assign fwd_a_d = fwdD[0];
   assign fwd_b_d = fwdD[1];

   assign lu  = memread_e && (|hitE);
   assign brE = branch_d && regwrite_e && !memread_e && (|hitE);
   assign brM = branch_d && memread_m && (|hitM);
   assign md  = md_use_d && (md_busy || md_start_e);
   assign hz  = lu || brE || brM || md || (ldCnt != '0);

   assign stall_f = hz;
   assign stall_d = hz;
   assign flush_e = hz;
   // A stalled branch is re-evaluated next cycle, so its flush waits until then.
   assign flush_d = taken_d && !hz;

   assign md_busy = (mdCnt != '0);

   // The detection cycle is the first bubble; ldCnt supplies the remaining ones.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                       ldCnt <= '0;
      else if (lu && ldCnt == '0)    ldCnt <= LD_INIT;
      else if (ldCnt != '0)          ldCnt <= ldCnt - LD_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                 mdCnt <= '0;
      else if (md_start_e)     mdCnt <= MD_INIT;
      else if (mdCnt != '0)    mdCnt <= mdCnt - MD_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                          stall_cnt <= '0;
      else if (cnt_clr)                 stall_cnt <= '0;
      else if (hz && stall_cnt != '1)   stall_cnt <= stall_cnt + CNT_W'(1);
   end
endmodule

// File: tb/tb_hazard_unit.sv
// Bench for hazard_unit: two instances (LOAD_LAT=1/CNT_W=16 and LOAD_LAT=3/CNT_W=3)
// share one stimulus stream; expected values go through a scoreboard queue.

module tb_hazard_unit;
   logic clk = 1'b0;
   logic rst;
   logic [4:0] rsD, rtD, rsE, rtE, dstE, dstM, dstW;
   logic useRsD, useRtD, branchD, takenD, mdUseD;
   logic regwriteE, memreadE, mdStartE, regwriteM, memreadM, regwriteW, cntClr;

   logic stallFA, stallDA, flushDA, flushEA, fwdADA, fwdBDA, mdBusyA;
   logic [1:0] fwdAEA, fwdBEA;
   logic [15:0] cntA;
   logic stallFB, stallDB, flushDB, flushEB, fwdADB, fwdBDB, mdBusyB;
   logic [1:0] fwdAEB, fwdBEB;
   logic [2:0] cntB;

   typedef struct {
      string tag;
      logic stA, stB, flA, flB;
      logic [1:0] faE, fbE;
      logic faD, fbD, busy;
      int cA, cB;
   } expT;

   expT sbq[$];
   int nChk = 0, nFail = 0;
   int mCntA = 0, mCntB = 0;

   always #5 clk = ~clk;

   hazard_unit #(.ADDR_W(5), .LOAD_LAT(1), .MD_LAT(4), .CNT_W(16)) uA (
      .clk(clk), .rst(rst), .rs_d(rsD), .rt_d(rtD), .use_rs_d(useRsD), .use_rt_d(useRtD),
      .branch_d(branchD), .taken_d(takenD), .md_use_d(mdUseD), .rs_e(rsE), .rt_e(rtE),
      .dst_e(dstE), .regwrite_e(regwriteE), .memread_e(memreadE), .md_start_e(mdStartE),
      .dst_m(dstM), .regwrite_m(regwriteM), .memread_m(memreadM), .dst_w(dstW),
      .regwrite_w(regwriteW), .cnt_clr(cntClr), .stall_f(stallFA), .stall_d(stallDA),
      .flush_d(flushDA), .flush_e(flushEA), .fwd_a_e(fwdAEA), .fwd_b_e(fwdBEA),
      .fwd_a_d(fwdADA), .fwd_b_d(fwdBDA), .md_busy(mdBusyA), .stall_cnt(cntA));

   hazard_unit #(.ADDR_W(5), .LOAD_LAT(3), .MD_LAT(4), .CNT_W(3)) uB (
      .clk(clk), .rst(rst), .rs_d(rsD), .rt_d(rtD), .use_rs_d(useRsD), .use_rt_d(useRtD),
      .branch_d(branchD), .taken_d(takenD), .md_use_d(mdUseD), .rs_e(rsE), .rt_e(rtE),
      .dst_e(dstE), .regwrite_e(regwriteE), .memread_e(memreadE), .md_start_e(mdStartE),
      .dst_m(dstM), .regwrite_m(regwriteM), .memread_m(memreadM), .dst_w(dstW),
      .regwrite_w(regwriteW), .cnt_clr(cntClr), .stall_f(stallFB), .stall_d(stallDB),
      .flush_d(flushDB), .flush_e(flushEB), .fwd_a_e(fwdAEB), .fwd_b_e(fwdBEB),
      .fwd_a_d(fwdADB), .fwd_b_d(fwdBDB), .md_busy(mdBusyB), .stall_cnt(cntB));

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nChk++;
      if (got !== exp) begin
         nFail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic idle();
      rsD = '0; rtD = '0; rsE = '0; rtE = '0; dstE = '0; dstM = '0; dstW = '0;
      useRsD = 0; useRtD = 0; branchD = 0; takenD = 0; mdUseD = 0;
      regwriteE = 0; memreadE = 0; mdStartE = 0; regwriteM = 0; memreadM = 0;
      regwriteW = 0; cntClr = 0;
   endtask

   // Inputs are already driven; push expectations, compare at the falling edge,
   // then advance the counter model by what the next rising edge should do.
   task automatic step(input string tag, input logic stA, input logic stB,
                       input logic flA, input logic flB, input logic [1:0] faE,
                       input logic [1:0] fbE, input logic faD, input logic fbD,
                       input logic busy);
      expT e;
      if (rst) begin mCntA = 0; mCntB = 0; end
      e.tag = tag; e.stA = stA; e.stB = stB; e.flA = flA; e.flB = flB;
      e.faE = faE; e.fbE = fbE; e.faD = faD; e.fbD = fbD; e.busy = busy;
      e.cA = mCntA; e.cB = mCntB;
      sbq.push_back(e);
      @(negedge clk);
      e = sbq.pop_front();
      chk({e.tag, ".stallF.A"}, 32'(stallFA), 32'(e.stA));
      chk({e.tag, ".stallD.A"}, 32'(stallDA), 32'(e.stA));
      chk({e.tag, ".flushE.A"}, 32'(flushEA), 32'(e.stA));
      chk({e.tag, ".stallF.B"}, 32'(stallFB), 32'(e.stB));
      chk({e.tag, ".stallD.B"}, 32'(stallDB), 32'(e.stB));
      chk({e.tag, ".flushE.B"}, 32'(flushEB), 32'(e.stB));
      chk({e.tag, ".flushD.A"}, 32'(flushDA), 32'(e.flA));
      chk({e.tag, ".flushD.B"}, 32'(flushDB), 32'(e.flB));
      chk({e.tag, ".fwdAE.A"}, 32'(fwdAEA), 32'(e.faE));
      chk({e.tag, ".fwdBE.A"}, 32'(fwdBEA), 32'(e.fbE));
      chk({e.tag, ".fwdAE.B"}, 32'(fwdAEB), 32'(e.faE));
      chk({e.tag, ".fwdBE.B"}, 32'(fwdBEB), 32'(e.fbE));
      chk({e.tag, ".fwdAD.A"}, 32'(fwdADA), 32'(e.faD));
      chk({e.tag, ".fwdBD.A"}, 32'(fwdBDA), 32'(e.fbD));
      chk({e.tag, ".fwdAD.B"}, 32'(fwdADB), 32'(e.faD));
      chk({e.tag, ".fwdBD.B"}, 32'(fwdBDB), 32'(e.fbD));
      chk({e.tag, ".busy.A"}, 32'(mdBusyA), 32'(e.busy));
      chk({e.tag, ".busy.B"}, 32'(mdBusyB), 32'(e.busy));
      chk({e.tag, ".cnt.A"}, 32'(cntA), 32'(e.cA));
      chk({e.tag, ".cnt.B"}, 32'(cntB), 32'(e.cB));
      if (rst || cntClr) begin
         mCntA = 0; mCntB = 0;
      end else begin
         if (e.stA && mCntA < 65535) mCntA++;
         if (e.stB && mCntB < 7) mCntB++;
      end
      @(posedge clk); #1;
   endtask

   initial begin
      rst = 1'b1;
      idle();
      step("rst", 0,0, 0,0, 2'b00,2'b00, 0,0, 0);
      rst = 1'b0;

      // load-use on rs: lw $8 in E, consumer in D
      idle(); memreadE = 1; regwriteE = 1; dstE = 5'd8; rsD = 5'd8; useRsD = 1;
      step("lu0", 1,1, 0,0, 2'b00,2'b00, 0,0, 0);
      idle(); memreadM = 1; regwriteM = 1; dstM = 5'd8; rsD = 5'd8; useRsD = 1;
      step("lu1", 0,1, 0,0, 2'b00,2'b00, 0,0, 0);
      idle(); regwriteW = 1; dstW = 5'd8; rsE = 5'd8;
      step("lu2", 0,1, 0,0, 2'b01,2'b00, 0,0, 0);
      idle();
      step("lu3", 0,0, 0,0, 2'b00,2'b00, 0,0, 0);
      idle(); memreadE = 1; regwriteE = 1; dstE = 5'd0; rsD = 5'd0; useRsD = 1;
      step("luZero", 0,0, 0,0, 2'b00,2'b00, 0,0, 0);
      idle(); memreadE = 1; regwriteE = 1; dstE = 5'd7; rsD = 5'd7; rtD = 5'd3; useRtD = 1;
      step("luNoUse", 0,0, 0,0, 2'b00,2'b00, 0,0, 0);

      // branch on $9 after ALU write, taken held
      idle(); branchD = 1; takenD = 1; rsD = 5'd9; useRsD = 1; regwriteE = 1; dstE = 5'd9;
      step("brA0", 1,1, 0,0, 2'b00,2'b00, 0,0, 0);
      idle(); branchD = 1; takenD = 1; rsD = 5'd9; useRsD = 1; regwriteM = 1; dstM = 5'd9;
      step("brA1", 0,0, 1,1, 2'b00,2'b00, 1,0, 0);
      idle();
      step("brA2", 0,0, 0,0, 2'b00,2'b00, 0,0, 0);

      // branch on $9 (rt) after lw, taken held
      idle(); branchD = 1; takenD = 1; rtD = 5'd9; useRtD = 1;
      memreadE = 1; regwriteE = 1; dstE = 5'd9;
      step("brL0", 1,1, 0,0, 2'b00,2'b00, 0,0, 0);
      idle(); branchD = 1; takenD = 1; rtD = 5'd9; useRtD = 1;
      memreadM = 1; regwriteM = 1; dstM = 5'd9;
      step("brL1", 1,1, 0,0, 2'b00,2'b00, 0,0, 0);
      idle(); branchD = 1; takenD = 1; rtD = 5'd9; useRtD = 1; regwriteW = 1; dstW = 5'd9;
      step("brL2", 0,1, 1,0, 2'b00,2'b00, 0,0, 0);
      idle();
      step("brL3", 0,0, 0,0, 2'b00,2'b00, 0,0, 0);

      // forwarding priority and register 0
      idle(); rsE = 5'd5; rtE = 5'd5; regwriteM = 1; dstM = 5'd5; regwriteW = 1; dstW = 5'd5;
      step("fwdMW", 0,0, 0,0, 2'b10,2'b10, 0,0, 0);
      idle(); rsE = 5'd5; rtE = 5'd6; regwriteM = 1; dstM = 5'd6; regwriteW = 1; dstW = 5'd5;
      step("fwdMix", 0,0, 0,0, 2'b01,2'b10, 0,0, 0);
      idle(); regwriteM = 1; regwriteW = 1;
      step("fwdZero", 0,0, 0,0, 2'b00,2'b00, 0,0, 0);
      idle(); rsE = 5'd5; rtE = 5'd5; dstM = 5'd5; dstW = 5'd5;
      step("fwdNoWr", 0,0, 0,0, 2'b00,2'b00, 0,0, 0);
      idle(); branchD = 1; useRsD = 1; useRtD = 1; regwriteM = 1; regwriteE = 1;
      step("brZero", 0,0, 0,0, 2'b00,2'b00, 0,0, 0);
      idle(); branchD = 1; rtD = 5'd4; regwriteM = 1; dstM = 5'd4;
      step("fwdBD", 0,0, 0,0, 2'b00,2'b00, 0,1, 0);
      idle(); takenD = 1;
      step("jump", 0,0, 1,1, 2'b00,2'b00, 0,0, 0);

      // mul/div then mfhi
      idle(); mdStartE = 1;
      step("md0", 0,0, 0,0, 2'b00,2'b00, 0,0, 0);
      for (int i = 0; i < 4; i++) begin
         idle(); mdUseD = 1;
         step("mdStall", 1,1, 0,0, 2'b00,2'b00, 0,0, 1);
      end
      idle(); mdUseD = 1;
      step("mdDone", 0,0, 0,0, 2'b00,2'b00, 0,0, 0);

      // restart while busy reloads the full latency
      idle(); mdStartE = 1;
      step("mdRs0", 0,0, 0,0, 2'b00,2'b00, 0,0, 0);
      idle(); mdStartE = 1;
      step("mdRs1", 0,0, 0,0, 2'b00,2'b00, 0,0, 1);
      for (int i = 0; i < 5; i++) begin
         idle();
         step("mdRsRun", 0,0, 0,0, 2'b00,2'b00, 0,0, (i < 4) ? 1'b1 : 1'b0);
      end

      // asynchronous reset in the middle of a mul/div stall
      idle(); mdStartE = 1;
      step("mdR0", 0,0, 0,0, 2'b00,2'b00, 0,0, 0);
      idle(); mdUseD = 1;
      step("mdR1", 1,1, 0,0, 2'b00,2'b00, 0,0, 1);
      idle(); mdUseD = 1; rst = 1'b1;
      step("mdRst", 0,0, 0,0, 2'b00,2'b00, 0,0, 0);
      rst = 1'b0;
      idle(); mdUseD = 1;
      step("mdRel", 0,0, 0,0, 2'b00,2'b00, 0,0, 0);

      // counter saturation (B is 3 bits) and clear priority over increment
      idle(); cntClr = 1;
      step("clr", 0,0, 0,0, 2'b00,2'b00, 0,0, 0);
      for (int i = 0; i < 10; i++) begin
         idle(); mdUseD = 1; mdStartE = 1;
         step("sat", 1,1, 0,0, 2'b00,2'b00, 0,0, (i == 0) ? 1'b0 : 1'b1);
      end
      idle(); mdUseD = 1; cntClr = 1;
      step("clrHz", 1,1, 0,0, 2'b00,2'b00, 0,0, 1);
      for (int i = 0; i < 4; i++) begin
         idle();
         step("drain", 0,0, 0,0, 2'b00,2'b00, 0,0, (i < 3) ? 1'b1 : 1'b0);
      end

      $display("[TB] %0d tests run, %0d failed", nChk, nFail);
      $finish;
   end
endmodule
